// File: rtl/multi_core_sim_hub_pkg.sv
// Shared types and helpers for the multi-core simulation hub.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multi_core_sim_hub_pkg;

  // Each command word is split across 32-bit memory banks in every core.
  localparam int WORD_BITS  = 32;
  localparam int MEM_TO_CMD = 128 / WORD_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fproc_state_t;

  // The core-select field is never narrower than one bit, even for a single core.
  function automatic int csw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int mem_to_cmd(input int cmd_width);
    return cmd_width / WORD_BITS;
  endfunction

endpackage

// File: rtl/multi_core_sim_hub_rr_arbiter.sv
// Round-robin pick over a request vector, searching upward from ptr with wrap.
// Latency: combinational.
// Backpressure: none; caller decides when to consume the grant.
module rr_arbiter
  import multi_core_sim_hub_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  int            j;
  logic [IW-1:0] jj;

  // First requester at or after ptr wins; ptr is always kept below N.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!grant_any && req[jj]) begin
        grant_any = 1'b1;
        grant[jj] = 1'b1;
        grant_idx = jj;
      end
    end
  end

endmodule

// File: rtl/multi_core_sim_hub.sv
// Shared hub for N sim cores: time reference, command-memory write fan-out, sync barrier, fproc arbiter.
// Latency: cmd write 1 cycle; barrier release 1 cycle after completion; fproc request->result >= 3 cycles.
// Backpressure: none on cmd/sync; fproc requests are latched and served one at a time round-robin.
module multi_core_sim_hub
  import multi_core_sim_hub_pkg::*;
#(
  parameter int NUM_CORES          = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int CMD_WIDTH          = 128,
  parameter int CMD_ADDR_WIDTH     = 8,
  parameter int SYNC_BARRIER_WIDTH = 8,
  parameter int TREF_WIDTH         = 24,
  localparam int CSW               = csw_of(NUM_CORES),
  localparam int SBW               = SYNC_BARRIER_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CSW+CMD_ADDR_WIDTH-1:0] cmd_write_addr,
  input  logic [CMD_WIDTH-1:0]          cmd_write,
  input  logic                          cmd_write_enable,
  input  logic                          cmd_write_bcast,
  output logic [NUM_CORES-1:0]          core_mem_we,
  output logic [CMD_ADDR_WIDTH-1:0]     core_mem_addr,
  output logic [CMD_WIDTH-1:0]          core_mem_data,
  output logic [TREF_WIDTH-1:0]         phase_tref,
  input  logic [NUM_CORES-1:0]          sync_mask,
  input  logic                          ext_sync_enable,
  input  logic [NUM_CORES-1:0]          core_sync_en,
  input  logic [NUM_CORES*SBW-1:0]      core_sync_id,
  output logic [NUM_CORES-1:0]          core_sync_ready,
  output logic                          sync_error,
  input  logic [NUM_CORES-1:0]          core_fproc_en,
  input  logic [NUM_CORES*SBW-1:0]      core_fproc_id,
  output logic [NUM_CORES-1:0]          core_fproc_ready,
  output logic [DATA_WIDTH-1:0]         core_fproc_data,
  output logic                          fproc_en_out,
  output logic [SBW-1:0]                fproc_id,
  input  logic                          fproc_ready,
  input  logic [DATA_WIDTH-1:0]         fproc_data
);

  // ---------------- time reference ----------------
  // Free-running counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) phase_tref <= '0;
    else       phase_tref <= phase_tref + TREF_WIDTH'(1);
  end

  // ---------------- command write fan-out ----------------
  logic [CSW-1:0]       cmd_sel;
  logic [NUM_CORES-1:0] cmd_we;

  assign cmd_sel = cmd_write_addr[CSW+CMD_ADDR_WIDTH-1 -: CSW];

  // Decode target cores; an out-of-range select writes nobody.
  always_comb begin
    cmd_we = '0;
    if (cmd_write_bcast)                 cmd_we = '1;
    else if (int'(cmd_sel) < NUM_CORES)  cmd_we = NUM_CORES'(1) << cmd_sel;
  end

  // Register the write; addr/data follow the inputs even when no strobe is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_mem_we   <= '0;
      core_mem_addr <= '0;
      core_mem_data <= '0;
    end else begin
      core_mem_we   <= cmd_write_enable ? cmd_we : '0;
      core_mem_addr <= cmd_write_addr[CMD_ADDR_WIDTH-1:0];
      core_mem_data <= cmd_write;
    end
  end

  // ---------------- sync barrier ----------------
  logic [NUM_CORES-1:0] arrived, arrived_nxt, sync_new;
  logic [SBW-1:0]       ref_id, ref_nxt;
  logic                 ref_seen, sync_err_nxt, release_go;

  // Fold this cycle's fresh arrivals in; the lowest-index first arrival sets the reference id.
  always_comb begin
    sync_new     = core_sync_en & ~arrived;
    arrived_nxt  = arrived | sync_new;
    ref_seen     = |arrived;
    ref_nxt      = ref_id;
    sync_err_nxt = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (sync_new[i]) begin
        if (!sync_mask[i]) sync_err_nxt = 1'b1;
        if (ref_seen && (core_sync_id[i*SBW +: SBW] != ref_nxt)) sync_err_nxt = 1'b1;
        if (!ref_seen) begin
          ref_nxt  = core_sync_id[i*SBW +: SBW];
          ref_seen = 1'b1;
        end
      end
    end
    release_go = ext_sync_enable && (sync_mask != '0) &&
                 ((arrived_nxt & sync_mask) == sync_mask);
  end

  // Release pulses every arrived core for one cycle and restarts the barrier.
  always_ff @(posedge clk) begin
    if (reset) begin
      arrived         <= '0;
      ref_id          <= '0;
      core_sync_ready <= '0;
      sync_error      <= 1'b0;
    end else begin
      sync_error <= sync_error | sync_err_nxt;
      ref_id     <= ref_nxt;
      if (release_go) begin
        core_sync_ready <= arrived_nxt;
        arrived         <= '0;
      end else begin
        core_sync_ready <= '0;
        arrived         <= arrived_nxt;
      end
    end
  end

  // ---------------- fproc arbitration ----------------
  fproc_state_t             state;
  logic [NUM_CORES-1:0]     pending, grant;
  logic [NUM_CORES*SBW-1:0] req_id;
  logic [CSW-1:0]           rr_ptr, grant_idx;
  logic [NUM_CORES-1:0]     arb_grant;
  logic [CSW-1:0]           arb_idx;
  logic                     arb_any;

  rr_arbiter #(.N(NUM_CORES), .IW(CSW)) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Latch requests in any state, then issue/wait/return one request at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pending          <= '0;
      req_id           <= '0;
      rr_ptr           <= '0;
      grant            <= '0;
      grant_idx        <= '0;
      core_fproc_ready <= '0;
      core_fproc_data  <= '0;
      fproc_en_out     <= 1'b0;
      fproc_id         <= '0;
    end else begin
      core_fproc_ready <= '0;
      fproc_en_out     <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_fproc_en[i] && !pending[i]) begin
          pending[i]             <= 1'b1;
          req_id[i*SBW +: SBW]   <= core_fproc_id[i*SBW +: SBW];
        end
      end
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant        <= arb_grant;
            grant_idx    <= arb_idx;
            fproc_id     <= req_id[int'(arb_idx)*SBW +: SBW];
            fproc_en_out <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (fproc_ready) begin
            core_fproc_data    <= fproc_data;
            core_fproc_ready   <= grant;
            pending[grant_idx] <= 1'b0;
            rr_ptr             <= (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + CSW'(1);
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_core_sim_hub.sv
// Directed bench for multi_core_sim_hub: a 4-core instance plus a 3-core, 4-bit-tref instance
// used for the out-of-range core select and the time-reference wrap.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
module tb_multi_core_sim_hub;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   cmd_write_addr;
  logic [127:0] cmd_write;
  logic         cmd_write_enable, cmd_write_bcast;
  logic [3:0]   sync_mask, core_sync_en, core_fproc_en;
  logic         ext_sync_enable, fproc_ready;
  logic [31:0]  core_sync_id, core_fproc_id, fproc_data;

  logic [3:0]   core_mem_we, core_sync_ready, core_fproc_ready;
  logic [7:0]   core_mem_addr, fproc_id;
  logic [127:0] core_mem_data;
  logic [23:0]  phase_tref;
  logic         sync_error, fproc_en_out;
  logic [31:0]  core_fproc_data;

  logic [2:0]   b_mem_we, b_sync_ready, b_fproc_ready;
  logic [7:0]   b_mem_addr, b_fproc_id;
  logic [127:0] b_mem_data;
  logic [3:0]   b_tref;
  logic         b_sync_error, b_fproc_en_out;
  logic [31:0]  b_fproc_data;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] cyc_v;

  always #5 clk = ~clk;

  multi_core_sim_hub dut (
    .clk(clk), .reset(reset),
    .cmd_write_addr(cmd_write_addr), .cmd_write(cmd_write),
    .cmd_write_enable(cmd_write_enable), .cmd_write_bcast(cmd_write_bcast),
    .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr), .core_mem_data(core_mem_data),
    .phase_tref(phase_tref),
    .sync_mask(sync_mask), .ext_sync_enable(ext_sync_enable),
    .core_sync_en(core_sync_en), .core_sync_id(core_sync_id),
    .core_sync_ready(core_sync_ready), .sync_error(sync_error),
    .core_fproc_en(core_fproc_en), .core_fproc_id(core_fproc_id),
    .core_fproc_ready(core_fproc_ready), .core_fproc_data(core_fproc_data),
    .fproc_en_out(fproc_en_out), .fproc_id(fproc_id),
    .fproc_ready(fproc_ready), .fproc_data(fproc_data)
  );

  multi_core_sim_hub #(.NUM_CORES(3), .TREF_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_write_addr(cmd_write_addr), .cmd_write(cmd_write),
    .cmd_write_enable(cmd_write_enable), .cmd_write_bcast(cmd_write_bcast),
    .core_mem_we(b_mem_we), .core_mem_addr(b_mem_addr), .core_mem_data(b_mem_data),
    .phase_tref(b_tref),
    .sync_mask(3'b000), .ext_sync_enable(1'b0),
    .core_sync_en(3'b000), .core_sync_id(24'h0),
    .core_sync_ready(b_sync_ready), .sync_error(b_sync_error),
    .core_fproc_en(3'b000), .core_fproc_id(24'h0),
    .core_fproc_ready(b_fproc_ready), .core_fproc_data(b_fproc_data),
    .fproc_en_out(b_fproc_en_out), .fproc_id(b_fproc_id),
    .fproc_ready(1'b0), .fproc_data(32'h0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cmd_write_addr = '0; cmd_write = '0; cmd_write_enable = 1'b0; cmd_write_bcast = 1'b0;
    sync_mask = '0; ext_sync_enable = 1'b0; core_sync_en = '0; core_sync_id = '0;
    core_fproc_en = '0; core_fproc_id = '0; fproc_ready = 1'b0; fproc_data = '0;

    // ---- reset state ----
    tick(2);
    check("rst_we", core_mem_we, 4'b0);
    check("rst_addr", core_mem_addr, 8'h0);
    check("rst_data", core_mem_data, 128'h0);
    check("rst_tref", phase_tref, 24'h0);
    check("rst_sync_ready", core_sync_ready, 4'b0);
    check("rst_sync_error", sync_error, 1'b0);
    check("rst_fproc_ready", core_fproc_ready, 4'b0);
    check("rst_fproc_data", core_fproc_data, 32'h0);
    check("rst_fproc_en_out", fproc_en_out, 1'b0);
    check("rst_fproc_id", fproc_id, 8'h0);
    reset = 1'b0;
    cyc = 0;
    tick(1);
    check("tref_first", phase_tref, 24'h1);

    // ---- command write fan-out ----
    cmd_write_addr = {2'd2, 8'h10}; cmd_write = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    cmd_write_enable = 1'b1; cmd_write_bcast = 1'b0;
    tick(1);
    check("cmd_uni_we", core_mem_we, 4'b0100);
    check("cmd_uni_addr", core_mem_addr, 8'h10);
    check("cmd_uni_data", core_mem_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check("cmd_uni_we_b", b_mem_we, 3'b100);
    cmd_write_addr = {2'd1, 8'h22}; cmd_write = 128'hA5A5; cmd_write_bcast = 1'b1;
    tick(1);
    check("cmd_bcast_we", core_mem_we, 4'b1111);
    check("cmd_bcast_we_b", b_mem_we, 3'b111);
    check("cmd_bcast_addr", core_mem_addr, 8'h22);
    cmd_write_addr = {2'd3, 8'h33}; cmd_write_bcast = 1'b0;
    tick(1);
    check("cmd_sel3_we", core_mem_we, 4'b1000);
    check("cmd_sel_oob_we_b", b_mem_we, 3'b000);
    cmd_write_enable = 1'b0; cmd_write_addr = {2'd0, 8'h44};
    tick(1);
    check("cmd_noen_we", core_mem_we, 4'b0000);

    // ---- barrier: arrivals 0, 3, 1 complete mask 1011 ----
    sync_mask = 4'b1011; ext_sync_enable = 1'b1; core_sync_id = {8'd7, 8'd7, 8'd7, 8'd7};
    core_sync_en = 4'b0001; tick(1); core_sync_en = '0;
    check("bar_c0_ready", core_sync_ready, 4'b0000);
    tick(2);
    core_sync_en = 4'b1000; tick(1); core_sync_en = '0;
    check("bar_c3_ready", core_sync_ready, 4'b0000);
    tick(1);
    core_sync_en = 4'b0010; tick(1); core_sync_en = '0;
    check("bar_release", core_sync_ready, 4'b1011);
    check("bar_no_error", sync_error, 1'b0);
    tick(1);
    check("bar_release_1cyc", core_sync_ready, 4'b0000);

    // ---- barrier: id mismatch and held external enable ----
    ext_sync_enable = 1'b0;
    core_sync_en = 4'b0001; tick(1);
    core_sync_en = 4'b1000; core_sync_id = {8'd6, 8'd7, 8'd7, 8'd7}; tick(1);
    check("bar_id_mismatch", sync_error, 1'b1);
    core_sync_en = 4'b0010; core_sync_id = {8'd7, 8'd7, 8'd7, 8'd7}; tick(1); core_sync_en = '0;
    check("bar_held_a", core_sync_ready, 4'b0000);
    tick(2);
    check("bar_held_b", core_sync_ready, 4'b0000);
    ext_sync_enable = 1'b1; tick(1);
    check("bar_ext_release", core_sync_ready, 4'b1011);
    tick(1);
    check("bar_ext_release_1cyc", core_sync_ready, 4'b0000);
    check("bar_error_sticky", sync_error, 1'b1);

    // ---- fproc: cores 1 and 3 request together, pointer 0 ----
    core_fproc_id = {8'h33, 8'h00, 8'h11, 8'h00}; core_fproc_en = 4'b1010; tick(1); core_fproc_en = '0;
    check("fp_latch_no_issue", fproc_en_out, 1'b0);
    tick(1);
    check("fp_issue1_en", fproc_en_out, 1'b1);
    check("fp_issue1_id", fproc_id, 8'h11);
    fproc_ready = 1'b1; fproc_data = 32'hBEEF; tick(1); fproc_ready = 1'b0;
    check("fp_ready_in_issue_ignored", core_fproc_ready, 4'b0000);
    check("fp_data_unchanged", core_fproc_data, 32'h0);
    check("fp_issue1_pulse", fproc_en_out, 1'b0);
    tick(1);
    fproc_ready = 1'b1; fproc_data = 32'hDEAD;
    core_fproc_en = 4'b0010; core_fproc_id = {8'h33, 8'h00, 8'h55, 8'h00};
    tick(1); fproc_ready = 1'b0; core_fproc_en = '0;
    check("fp_result1_ready", core_fproc_ready, 4'b0010);
    check("fp_result1_data", core_fproc_data, 32'hDEAD);
    tick(1);
    check("fp_result1_1cyc", core_fproc_ready, 4'b0000);
    check("fp_issue3_en", fproc_en_out, 1'b1);
    check("fp_issue3_id", fproc_id, 8'h33);
    tick(1);
    check("fp_issue3_pulse", fproc_en_out, 1'b0);
    fproc_ready = 1'b1; fproc_data = 32'hCAFE; tick(1); fproc_ready = 1'b0;
    check("fp_result3_ready", core_fproc_ready, 4'b1000);
    check("fp_result3_data", core_fproc_data, 32'hCAFE);
    tick(1);
    check("fp_no_reissue_a", fproc_en_out, 1'b0);
    tick(1);
    check("fp_no_reissue_b", fproc_en_out, 1'b0);
    check("fp_idle_ready", core_fproc_ready, 4'b0000);

    // ---- time reference, including wrap of the 4-bit instance ----
    cyc_v = 32'(cyc);
    check("tref_count", phase_tref, cyc_v[23:0]);
    check("tref_wrap_b", b_tref, cyc_v[3:0]);

    // ---- reset while fproc waits and barrier arrivals are pending ----
    core_fproc_id = {8'h00, 8'h00, 8'h00, 8'h44}; core_fproc_en = 4'b0001;
    core_sync_en = 4'b1001;
    tick(1); core_fproc_en = '0; core_sync_en = '0;
    tick(2);
    reset = 1'b1; tick(1);
    check("mid_rst_tref", phase_tref, 24'h0);
    check("mid_rst_sync_error", sync_error, 1'b0);
    check("mid_rst_fproc_data", core_fproc_data, 32'h0);
    check("mid_rst_fproc_en_out", fproc_en_out, 1'b0);
    check("mid_rst_fproc_id", fproc_id, 8'h0);
    check("mid_rst_sync_ready", core_sync_ready, 4'b0000);
    reset = 1'b0; cyc = 0;
    fproc_ready = 1'b1; fproc_data = 32'h1234; core_sync_en = 4'b0010;
    tick(1); core_sync_en = '0;
    check("post_rst_sync_ready_a", core_sync_ready, 4'b0000);
    check("post_rst_fproc_ready_a", core_fproc_ready, 4'b0000);
    tick(1); fproc_ready = 1'b0;
    check("post_rst_sync_ready_b", core_sync_ready, 4'b0000);
    check("post_rst_fproc_ready_b", core_fproc_ready, 4'b0000);
    check("post_rst_fproc_data", core_fproc_data, 32'h0);
    tick(2);
    check("post_rst_no_issue", fproc_en_out, 1'b0);
    cyc_v = 32'(cyc);
    check("post_rst_tref", phase_tref, cyc_v[23:0]);
    core_sync_en = 4'b0100; tick(1); core_sync_en = '0;
    check("bar_unmasked_error", sync_error, 1'b1);
    check("bar_unmasked_no_release", core_sync_ready, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
